kbd_entry_ctrl: RTL and testbench
=================================

Name: kbd_entry_ctrl

Overview:
Sequencer sitting downstream of the keypad interface. It consumes filtered keypad scan codes, one strobe per received byte. It tracks make/break framing and assembles up to NDIGITS BCD digits into an edit buffer. On ENTER (keypad '*') it hands the finished entry to the consumer (game/calculator logic) over a valid/ack handshake. Keypad '-' acts as backspace, and an idle timeout discards stale partial entries.

Parameters:
NDIGITS, 4, max digits in an entry (1..8).
TIMEOUT_CYCLES, 32'd250_000_000, idle cycles with a non-empty buffer before auto-clear; 0 disables the timeout.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
key  input  8  filtered scan code: KP_0..KP_9, KP_STAR, KP_MINUS, KP_KEY_RELEASED (8'hF0) or KP_INVALID, per keycodes.vh
key_stb  input  1  one-cycle strobe; key is valid this cycle
entry_digits  output  4*NDIGITS  latched BCD entry, most-recent digit in [3:0], unused nibbles 0
entry_len  output  4  digit count of latched entry (0..NDIGITS)
entry_valid  output  1  latched entry available; held until ack
entry_ack  input  1  consumer accepts entry; sampled only while entry_valid=1
buf_digits  output  4*NDIGITS  live edit buffer (for display)
buf_len  output  4  live digit count
overflow  output  1  one-cycle pulse: digit dropped because buffer full
busy  output  1  1 while a key is held (state != S_IDLE)

Behaviour:
- Reset (async): all outputs 0; state S_IDLE; buffers cleared; timeout counter 0.
- All actions happen only on cycles with key_stb=1, except ack and timeout handling.
- Framing FSM:
  - S_IDLE: code 8'hF0 -> S_BREAK. Valid keypad code -> execute key action, latch code in held_code, -> S_HELD. KP_INVALID/other -> stay, no action.
  - S_HELD: code == held_code (typematic repeat) -> ignored, no action. 8'hF0 -> S_BREAK. Different valid code -> execute its action, update held_code, stay (rollover).
  - S_BREAK: any code -> S_IDLE, no action (break of any key). 8'hF0 -> stay S_BREAK.
- Key actions (1-cycle latency; results visible on the cycle after the strobe):
  - Digit d:
    - buf_len<NDIGITS -> buf_digits <= {buf_digits, d} (shift left 4), buf_len+1.
    - buf_len==NDIGITS -> buffer unchanged, overflow pulses 1 cycle.
  - KP_MINUS (backspace):
    - buf_len>0 -> buf_digits >> 4, buf_len-1.
    - buf_len==0 -> no-op.
  - KP_STAR (enter):
    - entry_valid=0 -> entry_digits/entry_len <= buffer, entry_valid<=1, buffer cleared. An empty buffer is a legal entry (len 0).
    - entry_valid=1 -> ignored; buffer kept.
- Handshake:
  - entry_valid falls the cycle after entry_ack=1 is sampled with entry_valid=1.
  - entry_digits/entry_len stay stable while valid.
  - ack and STAR in the same cycle: ack is processed first, so the new entry latches and entry_valid stays 1.
- Timeout:
  - Counter clears on every key_stb and whenever buf_len==0.
  - Otherwise it increments, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES the buffer clears (buf_len=0). FSM state and entry registers are unaffected.
- Reset mid-operation (held key, pending entry) discards everything, including an unacknowledged entry.

Test Plan:
1. Digit entry: strobe 8'h69 (1), F0, 69, then 8'h72 (2), F0, 72, then 8'h7C (STAR) -> entry_valid=1, entry_digits[7:0]=8'h12, entry_len=2, buf_len=0.
2. Typematic and rollover: strobe 73,73,73,F0,73 -> buf_len=1 (one '5'). Then 6B,74 without release -> buf_digits[11:0]=12'h546, busy=1 until F0 plus code.
3. Overflow/backspace (NDIGITS=4): enter 1,2,3,4,5 -> buf 16'h1234, one overflow pulse. Then 7B twice -> buf_len=2, buf 8'h12. Then 7B at len 0 -> no change.
4. Handshake: STAR with entry pending -> ignored, buffer retained. Assert entry_ack for 1 cycle -> entry_valid=0 next cycle. Ack and STAR in the same cycle -> entry_valid stays 1 with the new data.
5. Timeout (TIMEOUT_CYCLES=10): one digit then idle -> buf_len=0 at cycle 10 after the last strobe. A strobe at cycle 9 restarts the count.
6. Async reset asserted between edges while in S_HELD with entry_valid=1 -> all outputs 0 immediately. Next 8'h70 is treated as a fresh make.

Source files
------------

// File: rtl/kbd_entry_ctrl.sv
// Purpose : keypad entry sequencer. It takes filtered keypad scan codes, tracks make/break
//           framing, builds a BCD edit buffer, and hands the finished entry over valid/ack.
// Latency : one cycle from key_stb to the buffer, entry and overflow update. A timeout clear
//           takes effect TIMEOUT_CYCLES cycles after the last strobe.
// Backpressure: a pending (unacked) entry blocks ENTER, and the buffer is kept. An ack and an
//           ENTER in the same cycle latch the new entry back to back.
// Ports   : clk, reset (async, active-high); key/key_stb scan-code input;
//           entry_digits/entry_len/entry_valid/entry_ack latched-entry handshake;
//           buf_digits/buf_len live buffer for display; overflow pulse; busy = key framing active.
module kbd_entry_ctrl #(
  parameter int          NDIGITS        = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             key,
  input  logic                   key_stb,
  output logic [4*NDIGITS-1:0]   entry_digits,
  output logic [3:0]             entry_len,
  output logic                   entry_valid,
  input  logic                   entry_ack,
  output logic [4*NDIGITS-1:0]   buf_digits,
  output logic [3:0]             buf_len,
  output logic                   overflow,
  output logic                   busy
);

  // Keypad scan codes (PS/2 set 2, numeric keypad)
  localparam logic [7:0] KP_0     = 8'h70;
  localparam logic [7:0] KP_1     = 8'h69;
  localparam logic [7:0] KP_2     = 8'h72;
  localparam logic [7:0] KP_3     = 8'h7A;
  localparam logic [7:0] KP_4     = 8'h6B;
  localparam logic [7:0] KP_5     = 8'h73;
  localparam logic [7:0] KP_6     = 8'h74;
  localparam logic [7:0] KP_7     = 8'h6C;
  localparam logic [7:0] KP_8     = 8'h75;
  localparam logic [7:0] KP_9     = 8'h7D;
  localparam logic [7:0] KP_STAR  = 8'h7C;
  localparam logic [7:0] KP_MINUS = 8'h7B;
  localparam logic [7:0] KP_REL   = 8'hF0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HELD  = 2'd1;
  localparam logic [1:0] S_BREAK = 2'd2;

  localparam logic [3:0] LEN_MAX = 4'(NDIGITS);

  logic [1:0]           r_state;
  logic [7:0]           r_held_code;
  logic [4*NDIGITS-1:0] r_buf;
  logic [3:0]           r_buf_len;
  logic [4*NDIGITS-1:0] r_entry;
  logic [3:0]           r_entry_len;
  logic                 r_entry_valid;
  logic                 r_overflow;
  logic [31:0]          r_cnt;

  logic                 w_is_digit;
  logic [3:0]           w_digit;
  logic                 w_is_star;
  logic                 w_is_minus;
  logic                 w_is_valid;
  logic                 w_exec;
  logic                 w_ack;
  logic                 w_latch;
  logic                 w_timeout;
  logic [4*NDIGITS-1:0] w_digit_ext;

  always_comb begin
    w_is_digit = 1'b1;
    w_digit    = 4'd0;
    case (key)
      KP_0:    w_digit = 4'd0;
      KP_1:    w_digit = 4'd1;
      KP_2:    w_digit = 4'd2;
      KP_3:    w_digit = 4'd3;
      KP_4:    w_digit = 4'd4;
      KP_5:    w_digit = 4'd5;
      KP_6:    w_digit = 4'd6;
      KP_7:    w_digit = 4'd7;
      KP_8:    w_digit = 4'd8;
      KP_9:    w_digit = 4'd9;
      default: w_is_digit = 1'b0;
    endcase
  end

  always_comb begin
    w_digit_ext      = '0;
    w_digit_ext[3:0] = w_digit;
  end

  assign w_is_star  = (key == KP_STAR);
  assign w_is_minus = (key == KP_MINUS);
  assign w_is_valid = w_is_digit | w_is_star | w_is_minus;

  // A key acts on a fresh make, or on a rollover to a different key while one is held.
  // A typematic repeat of the held code is ignored.
  assign w_exec = key_stb && w_is_valid &&
                  ((r_state == S_IDLE) || (r_state == S_HELD && key != r_held_code));

  assign w_ack   = entry_ack && r_entry_valid;
  // The ack is honoured before ENTER, so an ENTER in the ack cycle still latches.
  assign w_latch = w_exec && w_is_star && (!r_entry_valid || w_ack);

  // The timeout fires on the edge where the count would reach TIMEOUT_CYCLES.
  // No strobe is present then, so it never collides with a key action.
  assign w_timeout = (TIMEOUT_CYCLES != 32'd0) && !key_stb && (r_buf_len != 4'd0) &&
                     (r_cnt == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_held_code <= 8'h00;
    end else if (key_stb) begin
      case (r_state)
        S_IDLE: begin
          if (key == KP_REL) begin
            r_state <= S_BREAK;
          end else if (w_is_valid) begin
            r_state     <= S_HELD;
            r_held_code <= key;
          end
        end
        S_HELD: begin
          if (key == KP_REL) begin
            r_state <= S_BREAK;
          end else if (w_is_valid && key != r_held_code) begin
            r_held_code <= key;
          end
        end
        S_BREAK: begin
          if (key != KP_REL) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf      <= '0;
      r_buf_len  <= 4'd0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (w_timeout) begin
        r_buf     <= '0;
        r_buf_len <= 4'd0;
      end else if (w_exec) begin
        if (w_is_digit) begin
          if (r_buf_len < LEN_MAX) begin
            r_buf     <= (r_buf << 4) | w_digit_ext;
            r_buf_len <= r_buf_len + 4'd1;
          end else begin
            r_overflow <= 1'b1;
          end
        end else if (w_is_minus) begin
          if (r_buf_len != 4'd0) begin
            r_buf     <= r_buf >> 4;
            r_buf_len <= r_buf_len - 4'd1;
          end
        end else if (w_latch) begin
          r_buf     <= '0;
          r_buf_len <= 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_entry       <= '0;
      r_entry_len   <= 4'd0;
      r_entry_valid <= 1'b0;
    end else if (w_latch) begin
      r_entry       <= r_buf;
      r_entry_len   <= r_buf_len;
      r_entry_valid <= 1'b1;
    end else if (w_ack) begin
      r_entry_valid <= 1'b0;
    end
  end

  // The idle counter runs only while the buffer holds digits. Any strobe restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 32'd0;
    end else if (key_stb || r_buf_len == 4'd0) begin
      r_cnt <= 32'd0;
    end else if (TIMEOUT_CYCLES != 32'd0 && r_cnt != TIMEOUT_CYCLES) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign entry_digits = r_entry;
  assign entry_len    = r_entry_len;
  assign entry_valid  = r_entry_valid;
  assign buf_digits   = r_buf;
  assign buf_len      = r_buf_len;
  assign overflow     = r_overflow;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_kbd_entry_ctrl.sv
module tb_kbd_entry_ctrl;

  localparam int NDIG = 4;

  logic              clk;
  logic              reset;
  logic [7:0]        key;
  logic              key_stb;
  logic [4*NDIG-1:0] entry_digits;
  logic [3:0]        entry_len;
  logic              entry_valid;
  logic              entry_ack;
  logic [4*NDIG-1:0] buf_digits;
  logic [3:0]        buf_len;
  logic              overflow;
  logic              busy;

  int checks;
  int failures;

  kbd_entry_ctrl #(.NDIGITS(NDIG), .TIMEOUT_CYCLES(32'd10)) dut (
    .clk          (clk),
    .reset        (reset),
    .key          (key),
    .key_stb      (key_stb),
    .entry_digits (entry_digits),
    .entry_len    (entry_len),
    .entry_valid  (entry_valid),
    .entry_ack    (entry_ack),
    .buf_digits   (buf_digits),
    .buf_len      (buf_len),
    .overflow     (overflow),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. It drives a one-cycle strobe and returns at the next negedge.
  task automatic strobe(input logic [7:0] k);
    key     = k;
    key_stb = 1'b1;
    @(negedge clk);
    key_stb = 1'b0;
    key     = 8'h00;
  endtask

  task automatic press(input logic [7:0] k);
    strobe(k);
    strobe(8'hF0);
    strobe(k);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    key       = 8'h00;
    key_stb   = 1'b0;
    entry_ack = 1'b0;
    #3;
    check("rst_entry_valid", 32'(entry_valid), 32'd0);
    check("rst_entry_len", 32'(entry_len), 32'd0);
    check("rst_entry_digits", 32'(entry_digits), 32'd0);
    check("rst_buf_len", 32'(buf_len), 32'd0);
    check("rst_buf_digits", 32'(buf_digits), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: digit entry, then ENTER
    press(8'h69);
    press(8'h72);
    check("t1_buf_12", 32'(buf_digits), 32'h0012);
    strobe(8'h7C);
    check("t1_valid", 32'(entry_valid), 32'd1);
    check("t1_entry_digits", 32'(entry_digits), 32'h0012);
    check("t1_entry_len", 32'(entry_len), 32'd2);
    check("t1_buf_len", 32'(buf_len), 32'd0);
    strobe(8'hF0);
    strobe(8'h7C);

    // 2: typematic repeat, then rollover
    strobe(8'h73); strobe(8'h73); strobe(8'h73); strobe(8'hF0); strobe(8'h73);
    check("t2_buf_len_1", 32'(buf_len), 32'd1);
    check("t2_buf_5", 32'(buf_digits), 32'h0005);
    check("t2_idle", 32'(busy), 32'd0);
    strobe(8'h6B);
    strobe(8'h74);
    check("t2_rollover_buf", 32'(buf_digits), 32'h0546);
    check("t2_busy_held", 32'(busy), 32'd1);
    strobe(8'hF0);
    check("t2_busy_break", 32'(busy), 32'd1);
    strobe(8'h74);
    check("t2_busy_released", 32'(busy), 32'd0);
    check("t2_buf_len_3", 32'(buf_len), 32'd3);

    // 3: backspace, overflow, then backspace at length 0
    press(8'h7B);
    check("t3_bs_buf", 32'(buf_digits), 32'h0054);
    press(8'h7B);
    press(8'h7B);
    check("t3_empty", 32'(buf_len), 32'd0);
    press(8'h69); press(8'h72); press(8'h7A); press(8'h6B);
    check("t3_buf_1234", 32'(buf_digits), 32'h1234);
    check("t3_no_ovf_yet", 32'(overflow), 32'd0);
    strobe(8'h73);
    check("t3_overflow_pulse", 32'(overflow), 32'd1);
    check("t3_buf_kept", 32'(buf_digits), 32'h1234);
    check("t3_len_full", 32'(buf_len), 32'd4);
    strobe(8'hF0);
    check("t3_overflow_ends", 32'(overflow), 32'd0);
    strobe(8'h73);
    press(8'h7B);
    press(8'h7B);
    check("t3_len_2", 32'(buf_len), 32'd2);
    check("t3_buf_12", 32'(buf_digits), 32'h0012);
    press(8'h7B);
    press(8'h7B);
    press(8'h7B);
    check("t3_bs_at_0_len", 32'(buf_len), 32'd0);
    check("t3_bs_at_0_buf", 32'(buf_digits), 32'h0000);

    // 4: handshake (entry 0012 is still pending)
    press(8'h7A);
    press(8'h6B);
    press(8'h7C);
    check("t4_star_ignored_valid", 32'(entry_valid), 32'd1);
    check("t4_star_ignored_entry", 32'(entry_digits), 32'h0012);
    check("t4_buf_retained", 32'(buf_digits), 32'h0034);
    check("t4_buf_len_retained", 32'(buf_len), 32'd2);
    entry_ack = 1'b1;
    @(negedge clk);
    entry_ack = 1'b0;
    check("t4_ack_drops_valid", 32'(entry_valid), 32'd0);
    press(8'h7C);
    check("t4_new_entry_valid", 32'(entry_valid), 32'd1);
    check("t4_new_entry", 32'(entry_digits), 32'h0034);
    check("t4_new_buf_len", 32'(buf_len), 32'd0);
    press(8'h7D);
    entry_ack = 1'b1;
    strobe(8'h7C);
    entry_ack = 1'b0;
    check("t4_ack_star_valid", 32'(entry_valid), 32'd1);
    check("t4_ack_star_digits", 32'(entry_digits), 32'h0009);
    check("t4_ack_star_len", 32'(entry_len), 32'd1);
    check("t4_ack_star_buf", 32'(buf_len), 32'd0);
    strobe(8'hF0);
    strobe(8'h7C);
    entry_ack = 1'b1;
    @(negedge clk);
    entry_ack = 1'b0;
    check("t4_final_ack", 32'(entry_valid), 32'd0);

    // 5: timeout of 10 idle cycles
    press(8'h70);
    check("t5_digit0_len", 32'(buf_len), 32'd1);
    repeat (9) @(negedge clk);
    check("t5_cycle9_kept", 32'(buf_len), 32'd1);
    @(negedge clk);
    check("t5_cycle10_cleared", 32'(buf_len), 32'd0);
    press(8'h69);
    repeat (8) @(negedge clk);
    strobe(8'hF0);
    check("t5_restart_kept", 32'(buf_len), 32'd1);
    repeat (9) @(negedge clk);
    check("t5_restart_cycle9", 32'(buf_len), 32'd1);
    @(negedge clk);
    check("t5_restart_cleared", 32'(buf_len), 32'd0);
    check("t5_state_kept", 32'(busy), 32'd1);
    strobe(8'h00);
    check("t5_break_exit", 32'(busy), 32'd0);

    // 6: async reset while a key is held and an entry is pending
    strobe(8'h69);
    strobe(8'h7C);
    check("t6_pre_valid", 32'(entry_valid), 32'd1);
    check("t6_pre_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(entry_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_entry", 32'(entry_digits), 32'h0000);
    check("t6_rst_entry_len", 32'(entry_len), 32'd0);
    check("t6_rst_buf_len", 32'(buf_len), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    strobe(8'h70);
    check("t6_fresh_make_len", 32'(buf_len), 32'd1);
    check("t6_fresh_make_busy", 32'(busy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
